// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state/error encodings and defaults for the instruction-fetch sequencer
package fetch_pkg;
  localparam int TIMEOUT_CYCLES_DEF = 256;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, VALID, HALTED, ERR} fetch_state_t;
  typedef enum logic [0:1] {ERR_NONE, ERR_BUS, ERR_TIMEOUT} err_code_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [0:W-1] o_count
);
  // clear has priority; increment stops once every bit is set
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_count <= '0;
    else if (i_clr) o_count <= '0;
    else if (i_inc && !(&o_count)) o_count <= o_count + W'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one memory request per instruction, stalls the branch facility until decode consumes
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int WAIT_CNT_W     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [0:63]           i_next_instr_addr,
  output logic                  o_bf_stall,
  input  logic                  i_halt,
  output logic                  o_mem_req,
  output logic [0:63]           o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [0:31]           i_mem_data,
  input  logic                  i_mem_err,
  output logic                  o_instr_valid,
  output logic [0:31]           o_instr,
  input  logic                  i_instr_ready,
  output logic                  o_fetch_err,
  output logic [0:1]            o_err_code,
  output logic [0:63]           o_retired_count,
  output logic [0:WAIT_CNT_W-1] o_wait_cycles
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  fetch_state_t state_q, state_d;
  err_code_t    err_q;
  logic [0:63]  addr_q, ret_q;
  logic [0:31]  instr_q;
  logic [TW-1:0] tmo_q;
  logic busy, consume, tmo_hit, good_ack;
  assign busy     = state_q == REQ || state_q == WAIT;
  assign consume  = state_q == VALID && i_instr_ready;
  assign tmo_hit  = state_q == WAIT && tmo_q == TW'(TIMEOUT_CYCLES - 2);
  assign good_ack = busy && i_mem_ack && !i_mem_err;
  // next state: ack beats timeout, bus error beats data, ERR only leaves via reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:       state_d = i_halt ? HALTED : REQ;
      REQ, WAIT:  state_d = i_mem_ack ? (i_mem_err ? ERR : VALID) : (tmo_hit ? ERR : WAIT);
      VALID:      state_d = consume ? (i_halt ? HALTED : REQ) : VALID;
      HALTED:     state_d = i_halt ? HALTED : REQ;
      default:    state_d = ERR;
    endcase
  end
  // state, timeout age (zero outside WAIT so every REQ entry starts fresh) and error code
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= BOOT;
      tmo_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      tmo_q   <= state_q == WAIT ? tmo_q + TW'(1) : '0;
      if (busy && state_d == ERR) err_q <= i_mem_ack ? ERR_BUS : ERR_TIMEOUT;
    end
  // datapath: address latched at boot and at each consume, word captured on a clean ack
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      addr_q  <= '0;
      instr_q <= '0;
      ret_q   <= '0;
    end else begin
      if (state_q == BOOT || consume) addr_q <= i_next_instr_addr;
      if (good_ack) instr_q <= i_mem_data;
      if (consume) ret_q <= ret_q + 64'd1;
    end
  sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (state_q == WAIT),
    .i_clr   (1'b0),
    .o_count (o_wait_cycles)
  );
  assign o_bf_stall      = !consume;
  assign o_mem_req       = busy;
  assign o_mem_addr      = addr_q;
  assign o_instr_valid   = state_q == VALID;
  assign o_instr         = instr_q;
  assign o_fetch_err     = state_q == ERR;
  assign o_err_code      = err_q;
  assign o_retired_count = ret_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus random traffic against a transaction-level model
module tb_fetch_sequencer;
  localparam int TMO = 8;
  logic        i_clk = 0, i_rst = 1;
  logic [0:63] i_next_instr_addr = '0;
  logic        i_halt = 0, i_mem_ack = 0, i_mem_err = 0, i_instr_ready = 0;
  logic [0:31] i_mem_data = '0;
  logic        o_bf_stall, o_mem_req, o_instr_valid, o_fetch_err;
  logic [0:63] o_mem_addr, o_retired_count;
  logic [0:31] o_instr, o_wait_cycles;
  logic [0:1]  o_err_code;
  int n_cmp = 0, n_bad = 0;
  bit          m_boot, m_req, m_valid, m_halt, m_err;
  logic [0:63] m_addr, m_ret;
  logic [0:31] m_instr, m_wait;
  logic [1:0]  m_code;
  int          age, lat;

  fetch_sequencer #(.TIMEOUT_CYCLES(TMO), .WAIT_CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_next_instr_addr(i_next_instr_addr),
    .o_bf_stall(o_bf_stall), .i_halt(i_halt), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .i_mem_err(i_mem_err), .o_instr_valid(o_instr_valid), .o_instr(o_instr),
    .i_instr_ready(i_instr_ready), .o_fetch_err(o_fetch_err), .o_err_code(o_err_code),
    .o_retired_count(o_retired_count), .o_wait_cycles(o_wait_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1; i_mem_ack = 0; i_mem_err = 0; i_halt = 0; i_instr_ready = 0;
    repeat (2) @(negedge i_clk);
    {m_req, m_valid, m_halt, m_err} = '0;
    m_boot = 1; m_addr = '0; m_ret = '0; m_instr = '0; m_wait = '0; m_code = 0; age = 0;
    chk("rst_req", o_mem_req, 0);
    chk("rst_valid", o_instr_valid, 0);
    chk("rst_stall", o_bf_stall, 1);
    chk("rst_err", o_fetch_err, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_ret", o_retired_count, 0);
    chk("rst_wait", o_wait_cycles, 0);
    chk("rst_instr", o_instr, 0);
    i_rst = 0;
  endtask

  // one clock: drive, compare outputs to the model, then advance the model by the spec's rules
  task automatic step(input bit ack, input bit err, input logic [0:31] d, input bit halt,
                      input bit rdy, input logic [0:63] na);
    i_mem_ack = ack; i_mem_err = err; i_mem_data = d; i_halt = halt;
    i_instr_ready = rdy; i_next_instr_addr = na;
    #1;
    chk("req", o_mem_req, m_req);
    chk("valid", o_instr_valid, m_valid);
    chk("stall", o_bf_stall, !(m_valid && rdy));
    chk("err", o_fetch_err, m_err);
    chk("code", o_err_code, m_code);
    chk("retired", o_retired_count, m_ret);
    chk("wait", o_wait_cycles, m_wait);
    if (m_req) chk("addr", o_mem_addr, m_addr);
    if (m_valid) chk("instr", o_instr, m_instr);
    @(posedge i_clk);
    if (m_boot) begin
      m_boot = 0; m_addr = na;
      if (halt) m_halt = 1; else begin m_req = 1; age = 0; end
    end else if (m_req) begin
      if (age > 0) m_wait++;
      if (ack) begin
        m_req = 0;
        if (err) begin m_err = 1; m_code = 1; end
        else begin m_valid = 1; m_instr = d; end
      end else if (age == TMO - 1) begin
        m_req = 0; m_err = 1; m_code = 2;
      end else age++;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 0; m_ret++; m_addr = na;
        if (halt) m_halt = 1; else begin m_req = 1; age = 0; end
      end
    end else if (m_halt && !halt) begin
      m_halt = 0; m_req = 1; age = 0;
    end
    @(negedge i_clk);
  endtask

  initial begin
    do_reset();
    step(0, 0, 0, 0, 1, 64'h0);
    chk("first_addr", o_mem_addr, 0);
    for (int k = 0; k < 6; k++) step(m_req, 0, 32'h48000010, 0, 1, 64'h10 * (k + 1));
    chk("ret3", o_retired_count, 3);
    for (int k = 0; k < 6; k++) step(age == 5, 0, 32'hcafe0005, 0, 0, 64'h0);
    chk("wait5", o_wait_cycles, 5);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 1, 64'h100);
    chk("addr_100", o_mem_addr, 64'h100);
    for (int k = 0; k < 4; k++) step(k == 3, 0, 32'h1234abcd, 1, 0, 64'h0);
    step(0, 0, 0, 1, 1, 64'h200);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 64'h0);
    chk("halted_no_req", o_mem_req, 0);
    step(0, 0, 0, 0, 0, 64'h0);
    chk("req_after_halt", o_mem_req, 1);
    chk("addr_200", o_mem_addr, 64'h200);
    lat = 0;
    for (int k = 0; k < 500; k++) begin
      if (m_req && age == 0) lat = $urandom_range(0, 6);
      step(m_req && age == lat, 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, {$urandom, $urandom});
    end
    do_reset();
    step(0, 0, 0, 0, 0, 64'h80);
    step(1, 1, 32'hbad0bad0, 0, 0, 64'h0);
    for (int k = 0; k < 5; k++) step($urandom_range(0, 1) == 1, 1, $urandom, 0, 1, 64'h0);
    chk("bus_code", o_err_code, 2'b01);
    chk("bus_valid", o_instr_valid, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 64'h0);
    for (int k = 0; k < TMO - 1; k++) step(0, 0, 0, 0, 0, 64'h0);
    chk("tmo_not_yet", o_fetch_err, 0);
    step(0, 0, 0, 0, 0, 64'h0);
    chk("tmo_code", o_err_code, 2'b10);
    chk("tmo_req", o_mem_req, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 64'h40);
    #2 i_rst = 1;
    #1 chk("async_drop_req", o_mem_req, 0);
    do_reset();
    step(1, 0, 32'hdeaddead, 0, 0, 64'h0);
    for (int k = 0; k < 4; k++) step(m_req, 0, 32'h600d600d, 0, 1, 64'h8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
